// File: rtl/mkio_manchester_tx.sv
// MIL-STD-1553 Manchester II word transmitter: sync + 16 data bits + odd parity,
// with a one-word holding register so that back-to-back words go out without a gap.
module mkio_manchester_tx #(
  parameter int HALF_BIT = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_cd,
  output logic        tx_busy,
  output logic        tx_p,
  output logic        tx_n,
  output logic        tx_inh,
  output logic        tx_active,
  output logic        tx_done,
  output logic        tx_lost
);

  localparam int DW = $clog2(HALF_BIT);
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_BIT - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_e;

  state_e      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]  hb_q, hb_d;
  logic [16:0] shift_q, shift_d;
  logic        cd_q, cd_d;
  logic [16:0] hold_q, hold_d;
  logic        full_q, full_d;
  logic        p_q, n_q, inh_q, active_q, done_q, lost_q;

  logic wrap, last, xfer, accept, lost_d, active_d, level_d, done_d;

  // Outputs are registered from next-state values so the line changes on the
  // same edge as the serialiser state.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hb_d    = hb_q;
    shift_d = shift_q;
    cd_d    = cd_q;
    hold_d  = hold_q;
    full_d  = full_q;

    wrap = (div_q == DIV_LAST);
    last = (state_q != IDLE) && wrap && (hb_q == 6'd39);
    xfer = full_q && ((state_q == IDLE) || last);

    if (state_q != IDLE) begin
      if (wrap) begin
        div_d = '0;
        hb_d  = hb_q + 6'd1;
        if (hb_q[0] && (hb_q >= 6'd7) && (hb_q != 6'd39))
          shift_d = {shift_q[15:0], 1'b0};
        case (state_q)
          SYNC:    if (hb_q == 6'd5)  state_d = DATA;
          DATA:    if (hb_q == 6'd37) state_d = PARITY;
          PARITY:  if (hb_q == 6'd39) begin
                     state_d = IDLE;
                     hb_d    = '0;
                   end
          default: ;
        endcase
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (xfer) begin
      state_d = SYNC;
      div_d   = '0;
      hb_d    = '0;
      cd_d    = hold_q[16];
      shift_d = {hold_q[15:0], ~^hold_q[15:0]};
      full_d  = 1'b0;
    end

    accept = tx_ready && (!full_q || xfer);
    if (accept) begin
      hold_d = {tx_cd, tx_data};
      full_d = 1'b1;
    end
    lost_d = tx_ready && !accept;

    active_d = (state_d != IDLE);
    if (hb_d < 6'd6)
      level_d = cd_d ? (hb_d < 6'd3) : (hb_d >= 6'd3);
    else
      level_d = shift_d[16] ^ hb_d[0];
    done_d = active_d && (hb_d == 6'd39) && (div_d == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      hb_q     <= '0;
      shift_q  <= '0;
      cd_q     <= 1'b0;
      hold_q   <= '0;
      full_q   <= 1'b0;
      p_q      <= 1'b0;
      n_q      <= 1'b0;
      inh_q    <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      hb_q     <= hb_d;
      shift_q  <= shift_d;
      cd_q     <= cd_d;
      hold_q   <= hold_d;
      full_q   <= full_d;
      p_q      <= active_d & level_d;
      n_q      <= active_d & ~level_d;
      inh_q    <= ~active_d;
      active_q <= active_d;
      done_q   <= done_d;
      lost_q   <= lost_d;
    end
  end

  assign tx_busy   = full_q;
  assign tx_p      = p_q;
  assign tx_n      = n_q;
  assign tx_inh    = inh_q;
  assign tx_active = active_q;
  assign tx_done   = done_q;
  assign tx_lost   = lost_q;

endmodule

// File: tb/tb_mkio_manchester_tx.sv
// Directed bench for mkio_manchester_tx at HALF_BIT=4 using hand-written 40-half-bit line patterns.
module tb_mkio_manchester_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_ready = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_cd = 1'b0;
  logic        tx_busy, tx_p, tx_n, tx_inh, tx_active, tx_done, tx_lost;

  int errors = 0;
  int checks = 0;

  // Half bit 0 is the MSB; 1 = tx_p high.
  localparam logic [39:0] PAT_0841 = 40'b111000_01010101_10010101_01100101_01010110_01;
  localparam logic [39:0] PAT_FFFF = 40'b000111_10101010_10101010_10101010_10101010_10;
  localparam logic [39:0] PAT_AAAA = 40'b111000_10011001_10011001_10011001_10011001_10;
  localparam logic [39:0] PAT_5555 = 40'b000111_01100110_01100110_01100110_01100110_10;

  mkio_manchester_tx #(.HALF_BIT(4)) dut (
    .clk(clk), .reset(reset), .tx_ready(tx_ready), .tx_data(tx_data), .tx_cd(tx_cd),
    .tx_busy(tx_busy), .tx_p(tx_p), .tx_n(tx_n), .tx_inh(tx_inh), .tx_active(tx_active),
    .tx_done(tx_done), .tx_lost(tx_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe one word while idle; checks the cycle right after the accepting edge.
  task automatic start_word(input logic cd, input logic [15:0] data);
    @(negedge clk);
    tx_ready = 1'b1; tx_cd = cd; tx_data = data;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("lat_busy1", {63'd0, tx_busy}, 64'd1);
    chk("lat_line_idle", {61'd0, tx_p, tx_n, tx_inh}, 64'b001);
  endtask

  // Samples ncyc cycles of a word starting at the next negedge, optionally queueing
  // a word at cycle qcyc and firing an overrun strobe at cycle ocyc.
  task automatic word(input string tag, input logic [39:0] pat, input int ncyc,
                      input int qcyc, input logic qcd, input logic [15:0] qdata,
                      input int ocyc, output logic b0);
    int bad = 0, dcnt = 0, dpos = -1, lcnt = 0;
    logic lvl;
    b0 = 1'bx;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      lvl = pat[39 - c / 4];
      if ({tx_p, tx_n, tx_inh, tx_active} !== {lvl, ~lvl, 1'b0, 1'b1}) bad++;
      if (tx_done === 1'b1) begin dcnt++; dpos = c; end
      if (tx_lost === 1'b1) lcnt++;
      if (c == 0) b0 = tx_busy;
      tx_ready = (c == qcyc) || (c == ocyc);
      if (c == qcyc) begin tx_cd = qcd; tx_data = qdata; end
      if (c == ocyc) begin tx_cd = 1'b1; tx_data = 16'h1234; end
    end
    tx_ready = 1'b0;
    chk({tag, "_line"}, 64'(bad), 64'd0);
    chk({tag, "_lost"}, 64'(lcnt), (ocyc >= 0) ? 64'd1 : 64'd0);
    if (ncyc == 160) begin
      chk({tag, "_done_cnt"}, 64'(dcnt), 64'd1);
      chk({tag, "_done_pos"}, 64'(dpos), 64'd159);
    end
  endtask

  initial begin
    logic b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {57'd0, tx_busy, tx_p, tx_n, tx_inh, tx_active, tx_done, tx_lost}, 64'b0001000);
    reset = 1'b1;

    // command word, including latency
    start_word(1'b1, 16'h0841);
    word("cmd0841", PAT_0841, 160, -1, 1'b0, 16'h0, -1, b0);
    chk("lat_busy0", {63'd0, b0}, 64'd0);
    @(negedge clk);
    chk("cmd_end_idle", {60'd0, tx_p, tx_n, tx_inh, tx_active}, 64'b0010);

    // data word, all ones
    start_word(1'b0, 16'hFFFF);
    word("datFFFF", PAT_FFFF, 160, -1, 1'b0, 16'h0, -1, b0);
    @(negedge clk);
    chk("dat_end_idle", {63'd0, tx_inh}, 64'd1);

    // back-to-back with overrun of a third word
    start_word(1'b1, 16'hAAAA);
    word("b2b1", PAT_AAAA, 160, 3, 1'b0, 16'h5555, 6, b0);
    word("b2b2", PAT_5555, 160, -1, 1'b0, 16'h0, -1, b0);
    @(negedge clk);
    chk("b2b_end_idle", {62'd0, tx_inh, tx_busy}, 64'b10);

    // reset mid-word with a queued word pending
    start_word(1'b1, 16'h0841);
    word("rst_pre", PAT_0841, 80, 10, 1'b0, 16'hFFFF, -1, b0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid", {60'd0, tx_p, tx_n, tx_inh, tx_busy}, 64'b0010);
    reset = 1'b1;
    start_word(1'b1, 16'h0841);
    word("post_rst", PAT_0841, 160, -1, 1'b0, 16'h0, -1, b0);
    @(negedge clk);
    chk("post_rst_idle", {63'd0, tx_inh}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
